// File: rtl/hazard_sequencer_if.sv
// rtl/hazard_sequencer_if.sv - ID/EX hazard bus between pipeline controller and hazard sequencer
//
// Groups the ID-stage instruction descriptor, the EX redirect, and the hazard
// sequencer's stall/flush/forwarding/status outputs.
//   master : pipeline side, drives id_* and ex_redirect, observes results
//   slave  : hazard sequencer, observes id_* and ex_redirect, drives results
interface hazard_sequencer_if;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        id_reg_write;
  logic [4:0]  id_dest;
  logic        id_is_load;
  logic        ex_redirect;
  logic        stall;
  logic        flush;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [15:0] stall_count;
  logic        stall_err;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_reg_write, id_dest, id_is_load,
           ex_redirect,
    input  stall, flush, fwd_a, fwd_b, stall_count, stall_err
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_reg_write, id_dest, id_is_load,
           ex_redirect,
    output stall, flush, fwd_a, fwd_b, stall_count, stall_err
  );
endinterface

// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - 5-stage pipeline RAW stall, redirect flush and EX forwarding control
//
// Tracks in-flight register writes in a 3-entry shadow pipe (S1=EX, S2=MEM,
// S3=WB). Raises stall on RAW hazards against the ID instruction, flush on
// EX redirects (held FLUSH_CYCLES cycles), drives EX operand forwarding selects,
// and keeps a saturating stall counter plus a consecutive-stall watchdog.
// Ports:
//   clk    in  pipeline clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of hazard_sequencer_if:
//          id_* / ex_redirect in; stall, flush, fwd_a, fwd_b (combinational),
//          stall_count, stall_err (registered) out
module hazard_sequencer #(
  parameter int FWD_EN         = 1,
  parameter int RF_WRITE_FIRST = 1,
  parameter int FLUSH_CYCLES   = 2,
  parameter int MAX_STALL      = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_sequencer_if.slave bus
);

  typedef struct packed {
    logic       v;
    logic [4:0] dest;
    logic       load;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
  } shadow_t;

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] STALL_MAX  = 8'(MAX_STALL);

  shadow_t     s1, s2, s3, id_entry;
  logic [2:0]  flush_cnt;
  logic [7:0]  run_cnt;
  logic [15:0] stall_count_q;
  logic        stall_err_q;
  logic        m1, m2, m3, raw;
  logic        stall_c, flush_c;
  logic [1:0]  fwd_a_c, fwd_b_c;
  logic        unused_bits;

  // An entry only becomes valid when it really writes a non-zero register,
  // which is what keeps $zero from ever matching.
  always_comb begin
    id_entry        = '0;
    id_entry.v      = bus.id_reg_write & (bus.id_dest != 5'd0);
    id_entry.dest   = bus.id_dest;
    id_entry.load   = bus.id_is_load;
    id_entry.rs     = bus.id_rs;
    id_entry.rt     = bus.id_rt;
    id_entry.use_rs = bus.id_use_rs;
    id_entry.use_rt = bus.id_use_rt;
  end

  function automatic logic id_match(input shadow_t s, input logic use_rs, input logic [4:0] rs,
                                    input logic use_rt, input logic [4:0] rt);
    return s.v & ((use_rs & (rs == s.dest)) | (use_rt & (rt == s.dest)));
  endfunction

  always_comb begin
    m1 = id_match(s1, bus.id_use_rs, bus.id_rs, bus.id_use_rt, bus.id_rt);
    m2 = id_match(s2, bus.id_use_rs, bus.id_rs, bus.id_use_rt, bus.id_rt);
    m3 = id_match(s3, bus.id_use_rs, bus.id_rs, bus.id_use_rt, bus.id_rt);
    if (FWD_EN != 0) begin
      raw = m1 & s1.load;
    end else begin
      raw = m1 | m2 | (m3 & (RF_WRITE_FIRST == 0));
    end
    flush_c = bus.ex_redirect | (flush_cnt != 3'd0);
    // A flushed or empty ID slot never needs to wait.
    stall_c = raw & bus.id_valid & ~flush_c;
  end

  // MEM (S2) has priority over WB (S3) since it holds the younger value.
  // A load in S2 has no data yet; the load-use stall keeps that case away.
  always_comb begin
    fwd_a_c = 2'b00;
    fwd_b_c = 2'b00;
    if (FWD_EN != 0) begin
      if (s2.v & ~s2.load & s1.use_rs & (s1.rs == s2.dest)) fwd_a_c = 2'b01;
      else if (s3.v & s1.use_rs & (s1.rs == s3.dest))        fwd_a_c = 2'b10;
      if (s2.v & ~s2.load & s1.use_rt & (s1.rt == s2.dest)) fwd_b_c = 2'b01;
      else if (s3.v & s1.use_rt & (s1.rt == s3.dest))        fwd_b_c = 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1            <= '0;
      s2            <= '0;
      s3            <= '0;
      flush_cnt     <= 3'd0;
      run_cnt       <= 8'd0;
      stall_count_q <= 16'd0;
      stall_err_q   <= 1'b0;
    end else begin
      s3 <= s2;
      s2 <= s1;
      s1 <= (bus.id_valid & ~stall_c & ~flush_c) ? id_entry : '0;

      // Redirects arriving during a flush come from the wrong path; drop them.
      if (bus.ex_redirect && flush_cnt == 3'd0) begin
        flush_cnt <= FLUSH_INIT;
      end else if (flush_cnt != 3'd0) begin
        flush_cnt <= flush_cnt - 3'd1;
      end

      if (stall_c) begin
        if (stall_count_q != 16'hFFFF) stall_count_q <= stall_count_q + 16'd1;
        if (run_cnt != 8'hFF)          run_cnt       <= run_cnt + 8'd1;
        if (run_cnt == STALL_MAX)      stall_err_q   <= 1'b1;
      end else begin
        run_cnt <= 8'd0;
      end
    end
  end

  assign bus.stall       = stall_c;
  assign bus.flush       = flush_c;
  assign bus.fwd_a       = fwd_a_c;
  assign bus.fwd_b       = fwd_b_c;
  assign bus.stall_count = stall_count_q;
  assign bus.stall_err   = stall_err_q;

  // Operand fields of older entries are carried only to keep one entry format.
  assign unused_bits = ^{s2.rs, s2.rt, s2.use_rs, s2.use_rt,
                         s3.load, s3.rs, s3.rt, s3.use_rs, s3.use_rt};

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb/tb_hazard_sequencer.sv - directed self-checking bench for hazard_sequencer
module tb_hazard_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hazard_sequencer_if h0 ();
  hazard_sequencer_if h1 ();
  hazard_sequencer_if h2 ();

  hazard_sequencer #(.FWD_EN(1), .RF_WRITE_FIRST(1), .FLUSH_CYCLES(2), .MAX_STALL(15))
    u0 (.clk(clk), .rst_n(rst_n), .bus(h0.slave));
  hazard_sequencer #(.FWD_EN(0), .RF_WRITE_FIRST(1), .FLUSH_CYCLES(1), .MAX_STALL(1))
    u1 (.clk(clk), .rst_n(rst_n), .bus(h1.slave));
  hazard_sequencer #(.FWD_EN(0), .RF_WRITE_FIRST(0), .FLUSH_CYCLES(2), .MAX_STALL(3))
    u2 (.clk(clk), .rst_n(rst_n), .bus(h2.slave));

  task automatic drive(input int sel, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic rw, input logic [4:0] dest,
                       input logic ld);
    case (sel)
      0: begin h0.id_valid = v; h0.id_rs = rs; h0.id_rt = rt; h0.id_use_rs = urs; h0.id_use_rt = urt;
               h0.id_reg_write = rw; h0.id_dest = dest; h0.id_is_load = ld; end
      1: begin h1.id_valid = v; h1.id_rs = rs; h1.id_rt = rt; h1.id_use_rs = urs; h1.id_use_rt = urt;
               h1.id_reg_write = rw; h1.id_dest = dest; h1.id_is_load = ld; end
      default: begin h2.id_valid = v; h2.id_rs = rs; h2.id_rt = rt; h2.id_use_rs = urs; h2.id_use_rt = urt;
               h2.id_reg_write = rw; h2.id_dest = dest; h2.id_is_load = ld; end
    endcase
  endtask

  task automatic idle_all();
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    h0.ex_redirect = 1'b0;
    h1.ex_redirect = 1'b0;
    h2.ex_redirect = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_pipes();
    idle_all();
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_all();
    tick();
    #2;
    total++; if (h0.stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0h want=0", h0.stall); end
    total++; if (h0.flush !== 1'b0) begin bad++; $display("FAIL rst_flush got=%0h want=0", h0.flush); end
    total++; if ({h0.fwd_a, h0.fwd_b} !== 4'b0000) begin bad++; $display("FAIL rst_fwd got=%0h want=0", {h0.fwd_a, h0.fwd_b}); end
    total++; if (h0.stall_count !== 16'd0) begin bad++; $display("FAIL rst_count got=%0h want=0", h0.stall_count); end
    total++; if (h0.stall_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%0h want=0", h0.stall_err); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // lw $t0,0($sp) ; add $t1,$t0,$t2
  task automatic test_load_use();
    flush_pipes();
    drive(0, 1, 5'd29, 5'd0, 1, 0, 1, 5'd8, 1);
    #2;
    total++; if (h0.stall !== 1'b0) begin bad++; $display("FAIL lu_lw_stall got=%0h want=0", h0.stall); end
    tick();
    drive(0, 1, 5'd8, 5'd10, 1, 1, 1, 5'd9, 0);
    #2;
    total++; if (h0.stall !== 1'b1) begin bad++; $display("FAIL lu_stall1 got=%0h want=1", h0.stall); end
    tick();
    #2;
    total++; if (h0.stall !== 1'b0) begin bad++; $display("FAIL lu_stall2 got=%0h want=0", h0.stall); end
    tick();
    idle_all();
    #2;
    total++; if (h0.fwd_a !== 2'b10) begin bad++; $display("FAIL lu_fwd_a got=%0h want=2", h0.fwd_a); end
    total++; if (h0.fwd_b !== 2'b00) begin bad++; $display("FAIL lu_fwd_b got=%0h want=0", h0.fwd_b); end
    total++; if (h0.stall_count !== 16'd1) begin bad++; $display("FAIL lu_count got=%0h want=1", h0.stall_count); end
  endtask

  // add $t0,$t1,$t2 ; sub $t3,$t0,$t0 (adjacent, one nop apart, and MEM-over-WB)
  task automatic test_fwd_alu();
    flush_pipes();
    drive(0, 1, 5'd9, 5'd10, 1, 1, 1, 5'd8, 0);
    tick();
    drive(0, 1, 5'd8, 5'd8, 1, 1, 1, 5'd11, 0);
    #2;
    total++; if (h0.stall !== 1'b0) begin bad++; $display("FAIL alu_stall got=%0h want=0", h0.stall); end
    tick();
    idle_all();
    #2;
    total++; if ({h0.fwd_a, h0.fwd_b} !== 4'b0101) begin bad++; $display("FAIL alu_fwd_mem got=%0h want=5", {h0.fwd_a, h0.fwd_b}); end
    flush_pipes();
    drive(0, 1, 5'd9, 5'd10, 1, 1, 1, 5'd8, 0);
    tick();
    idle_all();
    tick();
    drive(0, 1, 5'd8, 5'd8, 1, 1, 1, 5'd11, 0);
    tick();
    idle_all();
    #2;
    total++; if ({h0.fwd_a, h0.fwd_b} !== 4'b1010) begin bad++; $display("FAIL alu_fwd_wb got=%0h want=a", {h0.fwd_a, h0.fwd_b}); end
    flush_pipes();
    drive(0, 1, 5'd9, 5'd10, 1, 1, 1, 5'd8, 0);
    tick();
    drive(0, 1, 5'd12, 5'd13, 1, 1, 1, 5'd8, 0);
    tick();
    drive(0, 1, 5'd8, 5'd14, 1, 1, 1, 5'd11, 0);
    tick();
    idle_all();
    #2;
    total++; if ({h0.fwd_a, h0.fwd_b} !== 4'b0100) begin bad++; $display("FAIL alu_mem_beats_wb got=%0h want=4", {h0.fwd_a, h0.fwd_b}); end
  endtask

  // add $t0 ; or $t5,$t0,$t4 without forwarding
  task automatic test_no_fwd();
    flush_pipes();
    drive(1, 1, 5'd9, 5'd10, 1, 1, 1, 5'd8, 0);
    tick();
    drive(1, 1, 5'd8, 5'd12, 1, 1, 1, 5'd13, 0);
    #2;
    total++; if (h1.stall !== 1'b1) begin bad++; $display("FAIL nf_stall1 got=%0h want=1", h1.stall); end
    total++; if ({h1.fwd_a, h1.fwd_b} !== 4'b0000) begin bad++; $display("FAIL nf_fwd1 got=%0h want=0", {h1.fwd_a, h1.fwd_b}); end
    tick();
    #2;
    total++; if (h1.stall !== 1'b1) begin bad++; $display("FAIL nf_stall2 got=%0h want=1", h1.stall); end
    total++; if (h1.stall_err !== 1'b0) begin bad++; $display("FAIL nf_err_early got=%0h want=0", h1.stall_err); end
    tick();
    #2;
    total++; if (h1.stall !== 1'b0) begin bad++; $display("FAIL nf_stall3 got=%0h want=0", h1.stall); end
    tick();
    idle_all();
    #2;
    total++; if ({h1.fwd_a, h1.fwd_b} !== 4'b0000) begin bad++; $display("FAIL nf_fwd2 got=%0h want=0", {h1.fwd_a, h1.fwd_b}); end
    total++; if (h1.stall_count !== 16'd2) begin bad++; $display("FAIL nf_count got=%0h want=2", h1.stall_count); end
    total++; if (h1.stall_err !== 1'b1) begin bad++; $display("FAIL nf_err got=%0h want=1", h1.stall_err); end
  endtask

  // Same pair with a regfile that cannot bypass WB: 3 stall cycles, watchdog limit 3 not exceeded
  task automatic test_no_fwd_rwf0();
    flush_pipes();
    drive(2, 1, 5'd9, 5'd10, 1, 1, 1, 5'd8, 0);
    tick();
    drive(2, 1, 5'd12, 5'd8, 1, 1, 1, 5'd13, 0);
    for (int i = 0; i < 3; i++) begin
      #2;
      total++; if (h2.stall !== 1'b1) begin bad++; $display("FAIL rwf0_stall%0d got=%0h want=1", i, h2.stall); end
      tick();
    end
    #2;
    total++; if (h2.stall !== 1'b0) begin bad++; $display("FAIL rwf0_release got=%0h want=0", h2.stall); end
    total++; if (h2.stall_count !== 16'd3) begin bad++; $display("FAIL rwf0_count got=%0h want=3", h2.stall_count); end
    total++; if (h2.stall_err !== 1'b0) begin bad++; $display("FAIL rwf0_err got=%0h want=0", h2.stall_err); end
  endtask

  task automatic test_flush();
    flush_pipes();
    drive(0, 1, 5'd29, 5'd0, 1, 0, 1, 5'd8, 1);
    tick();
    drive(0, 1, 5'd8, 5'd10, 1, 1, 1, 5'd9, 0);
    h0.ex_redirect = 1'b1;
    #2;
    total++; if (h0.flush !== 1'b1) begin bad++; $display("FAIL fl_c1 got=%0h want=1", h0.flush); end
    total++; if (h0.stall !== 1'b0) begin bad++; $display("FAIL fl_beats_stall got=%0h want=0", h0.stall); end
    tick();
    #2;
    total++; if (h0.flush !== 1'b1) begin bad++; $display("FAIL fl_c2 got=%0h want=1", h0.flush); end
    tick();
    h0.ex_redirect = 1'b0;
    #2;
    total++; if (h0.flush !== 1'b0) begin bad++; $display("FAIL fl_c3 got=%0h want=0", h0.flush); end
    total++; if (h0.stall !== 1'b0) begin bad++; $display("FAIL fl_c3_stall got=%0h want=0", h0.stall); end
    tick();
    #2;
    total++; if (h0.flush !== 1'b0) begin bad++; $display("FAIL fl_c4 got=%0h want=0", h0.flush); end
    flush_pipes();
    h1.ex_redirect = 1'b1;
    #2;
    total++; if (h1.flush !== 1'b1) begin bad++; $display("FAIL fl1_c1 got=%0h want=1", h1.flush); end
    tick();
    h1.ex_redirect = 1'b0;
    #2;
    total++; if (h1.flush !== 1'b0) begin bad++; $display("FAIL fl1_c2 got=%0h want=0", h1.flush); end
  endtask

  task automatic test_zero_reg();
    flush_pipes();
    drive(0, 1, 5'd29, 5'd0, 1, 0, 1, 5'd0, 1);
    tick();
    drive(0, 1, 5'd0, 5'd0, 1, 1, 1, 5'd9, 0);
    #2;
    total++; if (h0.stall !== 1'b0) begin bad++; $display("FAIL zero_stall got=%0h want=0", h0.stall); end
    tick();
    idle_all();
    #2;
    total++; if ({h0.fwd_a, h0.fwd_b} !== 4'b0000) begin bad++; $display("FAIL zero_fwd got=%0h want=0", {h0.fwd_a, h0.fwd_b}); end
    drive(0, 1, 5'd29, 5'd0, 1, 0, 1, 5'd8, 1);
    tick();
    drive(0, 0, 5'd8, 5'd10, 1, 1, 1, 5'd9, 0);
    #2;
    total++; if (h0.stall !== 1'b0) begin bad++; $display("FAIL invalid_id_stall got=%0h want=0", h0.stall); end
    total++; if (h0.stall_err !== 1'b0) begin bad++; $display("FAIL zero_err got=%0h want=0", h0.stall_err); end
  endtask

  task automatic test_reset_mid();
    flush_pipes();
    drive(2, 1, 5'd9, 5'd10, 1, 1, 1, 5'd8, 0);
    h0.ex_redirect = 1'b1;
    tick();
    h0.ex_redirect = 1'b0;
    drive(2, 1, 5'd8, 5'd10, 1, 1, 1, 5'd13, 0);
    #2;
    total++; if (h0.flush !== 1'b1) begin bad++; $display("FAIL rm_pre_flush got=%0h want=1", h0.flush); end
    total++; if (h2.stall !== 1'b1) begin bad++; $display("FAIL rm_pre_stall got=%0h want=1", h2.stall); end
    rst_n = 1'b0;
    #1;
    total++; if (h0.flush !== 1'b0) begin bad++; $display("FAIL rm_flush got=%0h want=0", h0.flush); end
    total++; if (h2.stall !== 1'b0) begin bad++; $display("FAIL rm_stall got=%0h want=0", h2.stall); end
    total++; if (h0.stall_count !== 16'd0) begin bad++; $display("FAIL rm_count0 got=%0h want=0", h0.stall_count); end
    total++; if (h2.stall_count !== 16'd0) begin bad++; $display("FAIL rm_count2 got=%0h want=0", h2.stall_count); end
    total++; if (h1.stall_err !== 1'b0) begin bad++; $display("FAIL rm_err got=%0h want=0", h1.stall_err); end
    total++; if ({h0.fwd_a, h0.fwd_b} !== 4'b0000) begin bad++; $display("FAIL rm_fwd got=%0h want=0", {h0.fwd_a, h0.fwd_b}); end
    idle_all();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_fwd_alu();
    test_no_fwd();
    test_no_fwd_rwf0();
    test_flush();
    test_zero_reg();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
